// File: rtl/e32_pkg.sv
// Shared E32 definitions: sequencer state encoding used by the top and by benches.
package e32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

endpackage

// File: rtl/e32_sequencer.sv
// Multi-cycle E32 instruction sequencer: ALU ops take 4 cycles FETCH..WRITEBACK, loads/stores 5.
// No backpressure; enable only gates the start of the next instruction (sampled in IDLE/WRITEBACK).
module e32_sequencer
    import e32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_io,
    input  logic        dec_writes_rd,
    input  logic        dec_is_halt,
    input  logic        dec_branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_o,
    output logic        fetch_sel,
    output logic        ir_load,
    output logic        opnd_load,
    output logic        mem_write,
    output logic        bus_write,
    output logic        rf_write,
    output logic        wb_sel_load,
    output logic [2:0]  state_o,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] retired_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pc and retired advance only when an instruction leaves WRITEBACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            retired_cnt <= '0;
        end else if (state == ST_WRITEBACK) begin
            pc          <= dec_branch_taken ? branch_target : pc + 32'd1;
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_sel   = 1'b0;
        ir_load     = 1'b0;
        opnd_load   = 1'b0;
        mem_write   = 1'b0;
        bus_write   = 1'b0;
        rf_write    = 1'b0;
        wb_sel_load = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_sel = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                ir_load   = 1'b1;
                state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                opnd_load = 1'b1;
                if (dec_is_halt)                       state_nxt = ST_HALT;
                else if (dec_is_load || dec_is_store)  state_nxt = ST_MEMORY;
                else                                   state_nxt = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                // A load+store combination behaves as a store.
                mem_write = dec_is_store & ~dec_is_io;
                bus_write = dec_is_store &  dec_is_io;
                state_nxt = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                rf_write    = dec_writes_rd & ~dec_is_store;
                wb_sel_load = dec_is_load;
                state_nxt   = enable ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pc_o    = pc;
    assign state_o = state;
    assign halted  = (state == ST_HALT);
    assign retired = retired_cnt;

endmodule

// File: tb/tb_e32_sequencer.sv
// Bench for e32_sequencer: queue-based instruction model checked every cycle, plus directed scenarios.
module tb_e32_sequencer;
    import e32_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_io = 1'b0;
    logic        dec_writes_rd = 1'b0, dec_is_halt = 1'b0, dec_branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] pc_o, retired;
    logic        fetch_sel, ir_load, opnd_load, mem_write, bus_write, rf_write, wb_sel_load, halted;
    logic [2:0]  state_o;

    logic [31:0] d2_pc, d2_retired;
    logic        d2_fetch_sel, d2_ir_load, d2_opnd_load, d2_mem_write, d2_bus_write;
    logic        d2_rf_write, d2_wb_sel_load, d2_halted;
    logic [2:0]  d2_state;

    e32_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_io(dec_is_io),
        .dec_writes_rd(dec_writes_rd), .dec_is_halt(dec_is_halt),
        .dec_branch_taken(dec_branch_taken), .branch_target(branch_target),
        .pc_o(pc_o), .fetch_sel(fetch_sel), .ir_load(ir_load), .opnd_load(opnd_load),
        .mem_write(mem_write), .bus_write(bus_write), .rf_write(rf_write),
        .wb_sel_load(wb_sel_load), .state_o(state_o), .halted(halted), .retired(retired)
    );

    e32_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_io(dec_is_io),
        .dec_writes_rd(dec_writes_rd), .dec_is_halt(dec_is_halt),
        .dec_branch_taken(dec_branch_taken), .branch_target(branch_target),
        .pc_o(d2_pc), .fetch_sel(d2_fetch_sel), .ir_load(d2_ir_load), .opnd_load(d2_opnd_load),
        .mem_write(d2_mem_write), .bus_write(d2_bus_write), .rf_write(d2_rf_write),
        .wb_sel_load(d2_wb_sel_load), .state_o(d2_state), .halted(d2_halted), .retired(d2_retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is a list of phases; the tail after EXECUTE is chosen from the flags seen there.
    int          m_cur  = 0;
    int          m_pend[$];
    bit          m_halt = 0;
    logic [31:0] m_pc   = 32'h0000_0000;
    logic [31:0] m_pc2  = 32'hFFFF_FFFF;
    logic [31:0] m_ret  = 32'h0;

    task automatic m_clear();
        m_pend.delete();
        m_cur  = 0;
        m_halt = 0;
        m_pc   = 32'h0000_0000;
        m_pc2  = 32'hFFFF_FFFF;
        m_ret  = 0;
    endtask

    task automatic m_step();
        if (m_cur == 3) begin
            if (dec_is_halt) m_halt = 1;
            else if (dec_is_load || dec_is_store) begin m_pend.push_back(4); m_pend.push_back(5); end
            else m_pend.push_back(5);
        end
        if (m_cur == 5) begin
            m_pc  = dec_branch_taken ? branch_target : m_pc + 1;
            m_pc2 = dec_branch_taken ? branch_target : m_pc2 + 1;
            m_ret = m_ret + 1;
        end
        if ((m_cur == 0 || m_cur == 5) && enable) begin
            m_pend.push_back(1); m_pend.push_back(2); m_pend.push_back(3);
        end
        if (m_halt)                  m_cur = 6;
        else if (m_pend.size() > 0)  m_cur = m_pend.pop_front();
        else                         m_cur = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_clear();
            else       m_step();
        end
    end

    // Per-cycle comparison plus strobe counters for the directed scenarios.
    bit trace_on = 0;
    int cnt_fetch, cnt_mem, cnt_bus, cnt_rf, cnt_wbs;
    int tr[$];

    initial begin
        forever begin
            @(negedge clk);
            chk("state", {29'd0, state_o}, m_cur);
            chk("pc", pc_o, m_pc);
            chk("pc_rst_ffff", d2_pc, m_pc2);
            chk("retired", retired, m_ret);
            chk("halted", {31'd0, halted}, {31'd0, m_cur == 6});
            chk("fetch_sel", {31'd0, fetch_sel}, {31'd0, m_cur == 1});
            chk("ir_load", {31'd0, ir_load}, {31'd0, m_cur == 2});
            chk("opnd_load", {31'd0, opnd_load}, {31'd0, m_cur == 3});
            chk("mem_write", {31'd0, mem_write}, {31'd0, m_cur == 4 && dec_is_store && !dec_is_io});
            chk("bus_write", {31'd0, bus_write}, {31'd0, m_cur == 4 && dec_is_store && dec_is_io});
            chk("rf_write", {31'd0, rf_write}, {31'd0, m_cur == 5 && dec_writes_rd && !dec_is_store});
            chk("wb_sel_load", {31'd0, wb_sel_load}, {31'd0, m_cur == 5 && dec_is_load});
            if (trace_on) begin
                cnt_fetch += fetch_sel;
                cnt_mem   += mem_write;
                cnt_bus   += bus_write;
                cnt_rf    += rf_write;
                cnt_wbs   += wb_sel_load;
                if (state_o != 3'd0 && state_o != 3'd6) tr.push_back(int'(state_o));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic set_flags(input bit ld, input bit st, input bit io, input bit wr,
                             input bit hl, input bit tk, input logic [31:0] tgt);
        dec_is_load = ld; dec_is_store = st; dec_is_io = io; dec_writes_rd = wr;
        dec_is_halt = hl; dec_branch_taken = tk; branch_target = tgt;
    endtask

    task automatic trace_start();
        cnt_fetch = 0; cnt_mem = 0; cnt_bus = 0; cnt_rf = 0; cnt_wbs = 0;
        tr.delete();
        trace_on = 1;
    endtask

    task automatic wait_idle_or_halt(input string name);
        int n;
        n = 0;
        while (state_o != 3'd0 && state_o != 3'd6 && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, state %0d never returned to IDLE/HALT", name, state_o);
        end
    endtask

    // One instruction with enable pulsed only at its start.
    task automatic run_one(input string name, input bit ld, input bit st, input bit io, input bit wr,
                           input bit hl, input bit tk, input logic [31:0] tgt);
        set_flags(ld, st, io, wr, hl, tk, tgt);
        trace_start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_idle_or_halt(name);
        trace_on = 0;
        set_flags(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int exp_seq[4] = '{1, 2, 3, 5};
        repeat (3) tick();
        chk("reset_state", {29'd0, state_o}, 32'd0);
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_retired", retired, 32'h0);
        chk("reset_strobes", {31'd0, fetch_sel | ir_load | opnd_load | mem_write | bus_write | rf_write}, 32'd0);
        reset = 1'b0;
        tick();

        // ALU op writing rd
        run_one("alu", 0, 0, 0, 1, 0, 0, 32'h0);
        chk("alu_len", tr.size(), 32'd4);
        for (int i = 0; i < 4 && i < tr.size(); i++) chk("alu_seq", tr[i], exp_seq[i]);
        chk("alu_rf_cycles", cnt_rf, 32'd1);
        chk("alu_pc", pc_o, 32'h1);
        chk("alu_retired", retired, 32'd1);
        chk("wrap_pc", d2_pc, 32'h0);

        // IO store with writes_rd set
        run_one("store_io", 0, 1, 1, 1, 0, 0, 32'h0);
        chk("sio_len", tr.size(), 32'd5);
        chk("sio_bus", cnt_bus, 32'd1);
        chk("sio_mem", cnt_mem, 32'd0);
        chk("sio_rf", cnt_rf, 32'd0);
        chk("sio_pc", pc_o, 32'h2);

        // Load
        run_one("load", 1, 0, 0, 1, 0, 0, 32'h0);
        chk("ld_len", tr.size(), 32'd5);
        chk("ld_rf", cnt_rf, 32'd1);
        chk("ld_wbs", cnt_wbs, 32'd1);
        chk("ld_retired", retired, 32'd3);

        // Taken branch
        run_one("branch", 0, 0, 0, 0, 0, 1, 32'h0000_0100);
        chk("br_pc", pc_o, 32'h0000_0100);

        // enable dropped during DECODE
        set_flags(0, 0, 0, 1, 0, 0, 32'h0);
        enable = 1'b1;
        tick();
        tick();
        chk("en_drop_decode", {29'd0, state_o}, 32'd2);
        enable = 1'b0;
        wait_idle_or_halt("en_drop");
        chk("en_drop_idle", {29'd0, state_o}, 32'd0);
        chk("en_drop_retired", retired, 32'd5);
        enable = 1'b1;
        tick();
        chk("en_reraise_fetch", {29'd0, state_o}, 32'd1);
        enable = 1'b0;
        wait_idle_or_halt("en_reraise");
        chk("en_pc", pc_o, 32'h0000_0102);

        // Memory store
        run_one("store_mem", 0, 1, 0, 0, 0, 0, 32'h0);
        chk("smem_mem", cnt_mem, 32'd1);
        chk("smem_bus", cnt_bus, 32'd0);

        // Halt is sticky and not counted
        run_one("halt", 0, 0, 0, 1, 1, 0, 32'h0);
        chk("halt_state", {29'd0, state_o}, 32'd6);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_retired", retired, 32'd7);
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        chk("halt_sticky", {29'd0, state_o}, 32'd6);
        chk("halt_pc", pc_o, 32'h0000_0103);
        pulse_reset();
        tick();

        // Reset pulse mid-MEMORY store
        set_flags(0, 1, 0, 1, 0, 0, 32'h0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_mem_state", {29'd0, state_o}, 32'd4);
        chk("mid_mem_strobe", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_state", {29'd0, state_o}, 32'd0);
        chk("rst_async_mem", {31'd0, mem_write}, 32'd0);
        chk("rst_async_pc", pc_o, 32'h0);
        #1;
        reset = 1'b0;
        trace_start();
        repeat (4) tick();
        trace_on = 0;
        chk("post_rst_mem", cnt_mem, 32'd0);
        chk("post_rst_rf", cnt_rf, 32'd0);
        chk("post_rst_idle", {29'd0, state_o}, 32'd0);

        // Randomized traffic, flags re-drawn every cycle
        for (int c = 0; c < 4000; c++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) pulse_reset();
            enable           = ($urandom_range(0, 7) != 0);
            dec_is_load      = ($urandom_range(0, 2) == 0);
            dec_is_store     = ($urandom_range(0, 2) == 0);
            dec_is_io        = $urandom_range(0, 1);
            dec_writes_rd    = ($urandom_range(0, 3) != 0);
            dec_is_halt      = ($urandom_range(0, 59) == 0);
            dec_branch_taken = ($urandom_range(0, 3) == 0);
            branch_target    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
